// File: rtl/mem_copy_master_if.sv
// Memory bus between an initiator and the BRAM controller.
//   mem_valid  initiator -> responder  transaction request, held until mem_ready
//   mem_ready  responder -> initiator  one-cycle completion strobe
//   mem_addr   initiator -> responder  word-aligned byte address
//   mem_wdata  initiator -> responder  write data
//   mem_wstrb  initiator -> responder  4'b0000 read, 4'b1111 write
//   mem_rdata  responder -> initiator  read data, valid in the mem_ready cycle
interface mem_copy_master_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_copy_master.sv
// Block-copy bus initiator. On an accepted start it copies len_words_i 32-bit
// words from src_addr_i to dst_addr_i, one read followed by one write per word,
// with one idle bus cycle after every completed transaction. A watchdog aborts
// a transaction that waits TIMEOUT_CYCLES cycles for mem_ready (0 disables it).
// Ports:
//   clk          clock, posedge
//   reset_n      asynchronous active-low reset
//   start_i      one-cycle request, honoured only while busy_o is low
//   src_addr_i   source byte address (bits [1:0] ignored)
//   dst_addr_i   destination byte address (bits [1:0] ignored)
//   len_words_i  word count, 0 allowed
//   busy_o       copy in progress (includes the done cycle)
//   done_o       one-cycle pulse on successful completion
//   error_o      sticky watchdog abort flag, cleared by the next accepted start
//   bus          memory bus, master side
module mem_copy_master #(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_W-1:0]     len_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  mem_copy_master_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_GAP, WR, WR_GAP, DONE, ERR
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic              in_txn;
  logic              timeout;

  assign in_txn  = (state_q == RD) || (state_q == WR);
  // wd_q counts completed waiting cycles of the current request, so the limit
  // is hit in the TIMEOUT_CYCLES-th high cycle of mem_valid.
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_q == TIMEOUT_CYCLES - 1);
  assign wd_d    = in_txn ? wd_q + 32'd1 : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      // ERR is not busy, so a start arriving there is accepted like in IDLE.
      IDLE, ERR: begin
        state_d = IDLE;
        if (start_i) begin
          src_d = src_addr_i & ~32'h3;
          dst_d = dst_addr_i & ~32'h3;
          cnt_d = len_words_i;
          err_d = 1'b0;
          if (len_words_i == '0) begin
            state_d = DONE;
          end else begin
            state_d = RD;
            addr_d  = src_addr_i & ~32'h3;
          end
        end
      end
      RD: begin
        if (bus.mem_ready) begin
          data_d  = bus.mem_rdata;
          state_d = RD_GAP;
        end else if (timeout) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      // Write data is only loaded while mem_valid is low, so it never moves
      // under a pending request and stays put through idle cycles.
      RD_GAP: begin
        state_d = WR;
        addr_d  = dst_q;
        wdata_d = data_q;
      end
      // The DONE cycle doubles as the idle cycle after the final write.
      WR: begin
        if (bus.mem_ready) begin
          state_d = (cnt_q == LEN_W'(1)) ? DONE : WR_GAP;
        end else if (timeout) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      WR_GAP: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - LEN_W'(1);
        addr_d  = src_q + 32'd4;
        state_d = RD;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_valid = in_txn;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = (state_q == WR) ? 4'hF : 4'h0;
  assign busy_o        = (state_q != IDLE) && (state_q != ERR);
  assign done_o        = (state_q == DONE);
  assign error_o       = err_q;

endmodule

// File: tb/tb_mem_copy_master.sv
`timescale 1ns/1ps
module tb_mem_copy_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src_addr_i = '0;
  logic [31:0] dst_addr_i = '0;
  logic [15:0] len_words_i = '0;
  logic        busy_o, done_o, error_o;

  mem_copy_master_if bus();

  mem_copy_master #(.LEN_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i),
    .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_words_i(len_words_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Responder memory and the model's own view of memory.
  bit [31:0] mem [bit [31:0]];
  bit [31:0] mm  [bit [31:0]];

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic fill(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    mm[a]  = v;
  endtask

  // Responder: ready in the lat-th cycle of mem_valid (lat 0 = never).
  int fix_lat = 4;
  bit rnd_lat = 0;
  bit noise = 0;
  int vcnt = 0;
  int lat = 0;
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n || !bus.mem_valid) begin
        vcnt = 0;
        bus.mem_ready = reset_n && noise && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = $urandom;
      end else begin
        vcnt++;
        if (vcnt == 1) lat = rnd_lat ? int'($urandom_range(1, 5)) : fix_lat;
        bus.mem_ready = (lat != 0) && (vcnt == lat);
        bus.mem_rdata = $urandom;
        if (bus.mem_ready) begin
          if (bus.mem_wstrb == 4'hF) mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = rdm(bus.mem_addr);
        end
      end
    end
  end

  // Reference model: a copy is the ordered list of transactions
  // rd src+4i, wr dst+4i (data = word read), built when start is accepted.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } txn_t;
  txn_t        q[$];
  bit          m_busy = 0, m_done = 0, m_err = 0, m_gap = 0, m_mv = 0;
  bit          n_busy, n_done, n_err, n_gap, n_mv;
  bit          prev_valid = 0;
  int          vhigh = 0, run_len = 0, done_cnt = 0, last_done_cyc = 0;
  int          rise_log[$];
  logic [31:0] addr_log[$];
  logic [31:0] last_wdata = '0;
  logic [31:0] ms, md, ra, wa, wd;
  bit [31:0]   tmp [bit [31:0]];

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", bus.mem_valid, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_wstrb", bus.mem_wstrb, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      q.delete();
      m_busy = 0; m_done = 0; m_err = 0; m_gap = 0; m_mv = 0;
      vhigh = 0; prev_valid = 0; last_wdata = '0;
    end else begin
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);
      chk("error", error_o, m_err);
      if (m_gap) chk("gap_valid_low", bus.mem_valid, 0);
      if (m_mv)  chk("gap_one_cycle", bus.mem_valid, 1);
      n_busy = m_done ? 1'b0 : m_busy;
      n_done = 0;
      n_err  = m_err;
      n_gap  = 0;
      n_mv   = m_gap && (q.size() > 0);
      if (bus.mem_valid) begin
        if (!prev_valid) rise_log.push_back(cyc);
        vhigh++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL txn_unexpected actual addr=%h required no request", bus.mem_addr);
        end else begin
          chk("addr", bus.mem_addr, q[0].addr);
          chk("wstrb", bus.mem_wstrb, q[0].wr ? 4'hF : 4'h0);
          if (q[0].wr) chk("wdata", bus.mem_wdata, q[0].wdata);
          if (bus.mem_ready) begin
            if (q[0].wr) mm[q[0].addr] = q[0].wdata;
            addr_log.push_back(q[0].addr);
            void'(q.pop_front());
            n_gap = 1; run_len = vhigh; vhigh = 0;
            if (q.size() == 0) n_done = 1;
          end else if (vhigh == TO) begin
            q.delete();
            n_gap = 1; n_busy = 0; n_err = 1; run_len = vhigh; vhigh = 0;
          end
        end
      end else begin
        chk("idle_wstrb", bus.mem_wstrb, 0);
        chk("idle_wdata", bus.mem_wdata, last_wdata);
        vhigh = 0;
      end
      if (done_o) begin done_cnt++; last_done_cyc = cyc; end
      if (!m_busy && start_i) begin
        ms = src_addr_i & ~32'h3;
        md = dst_addr_i & ~32'h3;
        tmp = mm;
        for (int i = 0; i < int'(len_words_i); i++) begin
          ra = ms + 32'(4 * i);
          wa = md + 32'(4 * i);
          wd = tmp.exists(ra) ? tmp[ra] : 32'h0;
          tmp[wa] = wd;
          q.push_back('{addr: ra, wr: 1'b0, wdata: 32'h0});
          q.push_back('{addr: wa, wr: 1'b1, wdata: wd});
        end
        n_busy = 1; n_err = 0;
        if (len_words_i == 16'd0) n_done = 1;
      end
      m_busy = n_busy; m_done = n_done; m_err = n_err; m_gap = n_gap; m_mv = n_mv;
      prev_valid = bus.mem_valid;
      last_wdata = bus.mem_wdata;
    end
  end

  // Issue one copy and wait (bounded) for done or error.
  bit rnd_start = 0;
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                          input int extra_k, output int t0);
    bit fin;
    @(posedge clk); #1;
    start_i = 1'b1; src_addr_i = s; dst_addr_i = d; len_words_i = 16'(len);
    t0 = cyc;
    fin = 0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(posedge clk); #1;
      start_i = busy_o && ((k == extra_k) || (rnd_start && $urandom_range(0, 7) == 0));
      src_addr_i = $urandom; dst_addr_i = $urandom; len_words_i = 16'($urandom);
      @(negedge clk);
      if (done_o || error_o) fin = 1;
    end
    start_i = 1'b0;
    if (!fin) begin
      checks++; errors++;
      $display("FAIL copy_timeout actual=no done/error required=done or error");
    end
    @(posedge clk); #1;
  endtask

  int t0, d0, found;
  logic [31:0] snap [8];
  logic [31:0] s, d;
  int len;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy, fixed 4-cycle responder.
    fill(32'h100, 32'hAAAA_0001); fill(32'h104, 32'hBBBB_0002); fill(32'h108, 32'hCCCC_0003);
    rise_log.delete();
    run_copy(32'h100, 32'h200, 3, -1, t0);
    chk("t1_first_valid", 32'(rise_log[0] - t0), 1);
    chk("t1_second_valid", 32'(rise_log[1] - t0), 6);
    chk("t1_done_cycle", 32'(last_done_cyc - t0), 30);
    chk("t1_mem200", rdm(32'h200), 32'hAAAA_0001);
    chk("t1_mem204", rdm(32'h204), 32'hBBBB_0002);
    chk("t1_mem208", rdm(32'h208), 32'hCCCC_0003);
    chk("t1_busy_after", busy_o, 0);

    // Zero-length copy.
    rise_log.delete();
    run_copy(32'h100, 32'h300, 0, -1, t0);
    chk("t2_done_cycle", 32'(last_done_cyc - t0), 1);
    chk("t2_no_valid", 32'(rise_log.size()), 0);

    // Unaligned source, destination wrapping through 2^32.
    fill(32'h100, 32'h1111_2222); fill(32'h104, 32'h3333_4444);
    addr_log.delete();
    run_copy(32'h103, 32'hFFFF_FFFC, 2, -1, t0);
    chk("t3_ntxn", 32'(addr_log.size()), 4);
    chk("t3_a0", addr_log[0], 32'h0000_0100);
    chk("t3_a1", addr_log[1], 32'hFFFF_FFFC);
    chk("t3_a2", addr_log[2], 32'h0000_0104);
    chk("t3_a3", addr_log[3], 32'h0000_0000);
    chk("t3_memtop", rdm(32'hFFFF_FFFC), 32'h1111_2222);
    chk("t3_mem0", rdm(32'h0), 32'h3333_4444);

    // Watchdog abort, then a clean copy clears error.
    fill(32'h300, 32'h5555_6666); fill(32'h304, 32'h7777_8888);
    fix_lat = 0;
    d0 = done_cnt;
    run_copy(32'h300, 32'h400, 2, -1, t0);
    chk("t4_valid_run", 32'(run_len), TO);
    chk("t4_error", error_o, 1);
    chk("t4_no_done", 32'(done_cnt - d0), 0);
    chk("t4_busy", busy_o, 0);
    fix_lat = 4;
    run_copy(32'h300, 32'h400, 2, -1, t0);
    chk("t4_error_cleared", error_o, 0);
    chk("t4_mem404", rdm(32'h404), 32'h7777_8888);

    // Ready exactly in the cycle the watchdog limit is reached.
    fix_lat = TO;
    run_copy(32'h300, 32'h500, 1, -1, t0);
    chk("t4b_run", 32'(run_len), TO);
    chk("t4b_no_error", error_o, 0);
    chk("t4b_mem500", rdm(32'h500), 32'h5555_6666);
    fix_lat = 4;

    // Start while busy is ignored.
    fill(32'h700, 32'h0BAD_F00D); fill(32'h704, 32'hFEED_BEEF);
    d0 = done_cnt;
    run_copy(32'h700, 32'h800, 2, 5, t0);
    chk("t5_one_done", 32'(done_cnt - d0), 1);
    chk("t5_mem800", rdm(32'h800), 32'h0BAD_F00D);
    chk("t5_mem804", rdm(32'h804), 32'hFEED_BEEF);

    // Overlapping forward copy propagates the first word.
    fill(32'h2000, 32'hC0FF_EE00); fill(32'h2004, 32'h1); fill(32'h2008, 32'h2); fill(32'h200C, 32'h3);
    run_copy(32'h2000, 32'h2004, 3, -1, t0);
    chk("ovl_mem200C", rdm(32'h200C), 32'hC0FF_EE00);

    // Reset during a write.
    @(posedge clk); #1;
    start_i = 1'b1; src_addr_i = 32'h100; dst_addr_i = 32'h900; len_words_i = 16'd3;
    @(posedge clk); #1 start_i = 1'b0;
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      @(negedge clk);
      if (bus.mem_valid && bus.mem_wstrb == 4'hF) found = 1;
    end
    chk("t6_reached_write", 32'(found), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_valid", bus.mem_valid, 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_done", done_o, 0);
    chk("t6_error", error_o, 0);
    @(negedge clk); @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_idle_busy", busy_o, 0);
    chk("t6_idle_valid", bus.mem_valid, 0);

    // Randomized copies with random latency, ready noise and stray starts.
    rnd_lat = 1; noise = 1; rnd_start = 1;
    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(0, 6);
      s = 32'h1000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      d = 32'h8000 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        snap[i] = $urandom;
        fill((s & ~32'h3) + 32'(4 * i), snap[i]);
      end
      d0 = done_cnt;
      run_copy(s, d, len, -1, t0);
      chk("rnd_done", 32'(done_cnt - d0), 1);
      for (int i = 0; i < len; i++)
        chk("rnd_dst", rdm((d & ~32'h3) + 32'(4 * i)), snap[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=still running required=finished");
    $fatal(1, "simulation time limit");
  end
endmodule
